event_pending_latch: RTL



---
 rtl/event_pending_latch_pkg.sv | 36 +++
 rtl/event_pending_latch_lowest_set_encoder.sv | 22 ++
 rtl/event_pending_latch.sv | 85 ++++++++
 3 files changed

// File: rtl/event_pending_latch_pkg.sv
// rtl/event_pending_latch_pkg.sv - shared defaults, saturation helper and next-state priority for event_pending_latch
package event_pending_latch_pkg;

  localparam int unsigned N_DEF      = 4;
  localparam int unsigned IDX_W_DEF  = $clog2(N_DEF);
  localparam int unsigned DROP_W_DEF = 4;

  // Resolution order for a pending flag: clear beats a new event, a new event beats a pop.
  typedef enum logic [1:0] {
    ACT_CLR  = 2'd0,
    ACT_SET  = 2'd1,
    ACT_POP  = 2'd2,
    ACT_HOLD = 2'd3
  } pend_action_e;

  function automatic int unsigned drop_sat_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  function automatic pend_action_e pend_action(input logic clr, input logic ev, input logic popped);
    if (clr) return ACT_CLR;
    if (ev) return ACT_SET;
    if (popped) return ACT_POP;
    return ACT_HOLD;
  endfunction

  function automatic logic pend_next(input pend_action_e act, input logic cur);
    case (act)
      ACT_CLR:  return 1'b0;
      ACT_SET:  return 1'b1;
      ACT_POP:  return 1'b0;
      default:  return cur;
    endcase
  endfunction

endpackage

// File: rtl/event_pending_latch_lowest_set_encoder.sv
// rtl/event_pending_latch_lowest_set_encoder.sv - priority encoder: lowest set bit index plus any-set flag
module lowest_set_encoder
  import event_pending_latch_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set index is written last.
  always_comb begin
    idx = '0;
    any = |vec;
    for (int k = N - 1; k >= 0; k--) begin
      if (vec[k]) idx = IDX_W'(k);
    end
  end

endmodule

// File: rtl/event_pending_latch.sv
// rtl/event_pending_latch.sv - sticky per-line pending flags with drop counter; EVENT_PENDING_LATCH_EDGE_EN selects edge detect
module event_pending_latch
  import event_pending_latch_pkg::*;
#(
  parameter int unsigned N      = N_DEF,
  parameter int unsigned IDX_W  = $clog2(N),
  parameter int unsigned DROP_W = DROP_W_DEF
) (
  input  logic              CLK,
  input  logic              ASYNCRESETN,
  input  logic [N-1:0]      I,
  input  logic [N-1:0]      MASK,
  input  logic              CLR,
  input  logic              READY,
  output logic              VALID,
  output logic [IDX_W-1:0]  IDX,
  output logic [N-1:0]      PENDING,
  output logic [DROP_W-1:0] DROPS
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned SUM_W = DROP_W + CNT_W;
  localparam logic [DROP_W-1:0] DROP_MAX = DROP_W'(drop_sat_max(DROP_W));

  logic [N-1:0]      pend_q, pend_d;
  logic [DROP_W-1:0] drops_q, drops_d;
  logic [N-1:0]      trig, ev, pop_vec, drop_vec;
  logic [CNT_W-1:0]  drop_cnt;
  logic [SUM_W-1:0]  drop_sum;
  logic              pop;

`ifdef EVENT_PENDING_LATCH_EDGE_EN
  logic [N-1:0] prev_q, prev_d;

  // prev tracks the raw input regardless of MASK so unmasking never fakes an edge.
  always_comb prev_d = I;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) prev_q <= '0;
    else              prev_q <= prev_d;
  end

  assign trig = ~prev_q;
`else
  assign trig = '1;
`endif

  lowest_set_encoder #(.N(N), .IDX_W(IDX_W)) u_enc (
    .vec (pend_q),
    .idx (IDX),
    .any (VALID)
  );

  assign pop = VALID & READY;

  always_comb begin
    ev       = I & MASK & trig;
    pop_vec  = pop ? (N'(1) << IDX) : '0;
    drop_vec = ev & pend_q & ~pop_vec;
    drop_cnt = '0;
    pend_d   = pend_q;
    for (int k = 0; k < N; k++) begin
      drop_cnt  = drop_cnt + CNT_W'(drop_vec[k]);
      pend_d[k] = pend_next(pend_action(CLR, ev[k], pop_vec[k]), pend_q[k]);
    end
    drop_sum = SUM_W'(drops_q) + SUM_W'(drop_cnt);
    if (CLR)                             drops_d = '0;
    else if (drop_sum > SUM_W'(DROP_MAX)) drops_d = DROP_MAX;
    else                                 drops_d = drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      pend_q  <= '0;
      drops_q <= '0;
    end else begin
      pend_q  <= pend_d;
      drops_q <= drops_d;
    end
  end

  assign PENDING = pend_q;
  assign DROPS   = drops_q;

endmodule
